// File: rtl/ex_mem_stage_pkg.sv
// Shared widths, halt FSM encoding and control-bundle layout for the core's pipeline registers.
package ex_mem_stage_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Control bundle bit offsets; a cleared bundle is a bubble.
  localparam int unsigned CTL_VALID  = 0;
  localparam int unsigned CTL_REG_WR = 1;
  localparam int unsigned CTL_MEM_RD = 2;
  localparam int unsigned CTL_MEM_WR = 3;
  localparam int unsigned CTL_W      = 4;

  localparam int unsigned DATA_W = 3 * DW + RW;

endpackage

// File: rtl/pipe_reg_en.sv
// Pipeline register with synchronous reset, bubble clear and load enable.
module pipe_reg_en #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with sticky halt FSM, illegal-control flag and
// forwarding / load-use hazard compare against the registered MEM state.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [DW-1:0] ex_pc_inc,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_wr,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic          ex_halt,
  input  logic          stall,
  input  logic          flush,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          mem_valid,
  output logic [DW-1:0] mem_result,
  output logic [DW-1:0] mem_store_data,
  output logic [DW-1:0] mem_pc_inc,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_wr,
  output logic          mem_mem_rd,
  output logic          mem_mem_wr,
  output logic          mem_halted,
  output logic          fwd_a,
  output logic          fwd_b,
  output logic          load_use,
  output logic          err
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   halted, clr, en, load, illegal, is_halt;

  logic [DATA_W-1:0] data_d, data_q;
  logic [CTL_W-1:0]  ctl_d, ctl_q;

  assign halted  = (state_q == ST_HALTED);
  // Halted state outranks stall, so it shares the bubble path with flush.
  assign clr     = flush | halted;
  assign en      = ~stall;
  assign load    = ~clr & en;
  assign illegal = ex_valid & ex_mem_rd & ex_mem_wr;
  assign is_halt = ex_valid & ex_halt;

  assign data_d = {ex_result, ex_store_data, ex_pc_inc, ex_rd};

  always_comb begin
    ctl_d             = '0;
    ctl_d[CTL_VALID]  = ex_valid;
    // HALT is captured as a valid instruction that performs no writes.
    ctl_d[CTL_REG_WR] = ex_valid & ex_reg_wr & ~ex_halt;
    ctl_d[CTL_MEM_RD] = ex_valid & ex_mem_rd & ~ex_mem_wr & ~ex_halt;
    ctl_d[CTL_MEM_WR] = ex_valid & ex_mem_wr & ~ex_mem_rd & ~ex_halt;
  end

  pipe_reg_en #(
    .W(DATA_W)
  ) u_data_reg (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (en),
    .d  (data_d),
    .q  (data_q)
  );

  pipe_reg_en #(
    .W(CTL_W)
  ) u_ctl_reg (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (en),
    .d  (ctl_d),
    .q  (ctl_q)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (load && is_halt) begin
      state_d = ST_HALTED;
    end
    if (load && illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign {mem_result, mem_store_data, mem_pc_inc, mem_rd} = data_q;
  assign mem_valid  = ctl_q[CTL_VALID];
  assign mem_reg_wr = ctl_q[CTL_REG_WR];
  assign mem_mem_rd = ctl_q[CTL_MEM_RD];
  assign mem_mem_wr = ctl_q[CTL_MEM_WR];
  assign mem_halted = halted;
  assign err        = err_q;

  assign fwd_a    = mem_valid & mem_reg_wr & ~mem_mem_rd & (mem_rd == id_rs);
  assign fwd_b    = mem_valid & mem_reg_wr & ~mem_mem_rd & (mem_rd == id_rt);
  assign load_use = mem_valid & mem_mem_rd & mem_reg_wr &
                    ((mem_rd == id_rs) | (mem_rd == id_rt));

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the MEM-stage contents.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt, stall, flush;
  logic [15:0] ex_result, ex_store_data, ex_pc_inc;
  logic [2:0]  ex_rd, id_rs, id_rt;
  logic        mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halted;
  logic        fwd_a, fwd_b, load_use, err;
  logic [15:0] mem_result, mem_store_data, mem_pc_inc;
  logic [2:0]  mem_rd;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of what the memory stage should be holding.
  logic        m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_halted, m_err;
  logic [15:0] m_result, m_store, m_pc;
  logic [2:0]  m_rd;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_pc_inc(ex_pc_inc), .ex_rd(ex_rd),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_halt(ex_halt), .stall(stall), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_pc_inc(mem_pc_inc), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
    .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_halted(mem_halted),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_bubble();
    m_valid = 0; m_reg_wr = 0; m_mem_rd = 0; m_mem_wr = 0;
    m_result = 0; m_store = 0; m_pc = 0; m_rd = 0;
  endtask

  // One clock edge; the model applies rst > flush > halted > stall > load.
  task automatic step();
    logic bad;
    @(posedge clk);
    if (rst) begin
      model_bubble(); m_halted = 0; m_err = 0;
    end else if (flush || m_halted) begin
      model_bubble();
    end else if (!stall) begin
      bad      = ex_valid && ex_mem_rd && ex_mem_wr;
      m_valid  = ex_valid;
      m_result = ex_result; m_store = ex_store_data; m_pc = ex_pc_inc; m_rd = ex_rd;
      m_reg_wr = ex_valid && ex_reg_wr && !ex_halt;
      m_mem_rd = ex_valid && ex_mem_rd && !bad && !ex_halt;
      m_mem_wr = ex_valid && ex_mem_wr && !bad && !ex_halt;
      if (ex_valid && ex_halt) m_halted = 1;
      if (bad) m_err = 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; ex_valid = 0; ex_reg_wr = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_halt = 0;
    stall = 0; flush = 0; ex_result = 0; ex_store_data = 0; ex_pc_inc = 0;
    ex_rd = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", mem_valid); end
    n_tests++; if ({mem_result, mem_store_data, mem_pc_inc, mem_rd} !== 51'd0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", {mem_result, mem_store_data, mem_pc_inc, mem_rd}); end
    n_tests++; if ({mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halted, err} !== 5'd0) begin n_fail++;
      $display("FAIL reset_ctl: got %b want 00000", {mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halted, err}); end
  endtask

  task automatic test_forward();
    do_reset();
    ex_valid = 1; ex_result = 16'h00F0; ex_rd = 3; ex_reg_wr = 1; id_rs = 3; id_rt = 0;
    step(); idle_inputs(); id_rs = 3; id_rt = 0; #1;
    n_tests++; if (mem_result !== 16'h00F0) begin n_fail++;
      $display("FAIL fwd_result: got %h want 00f0", mem_result); end
    n_tests++; if (mem_rd !== 3'd3 || mem_valid !== 1'b1) begin n_fail++;
      $display("FAIL fwd_rd_valid: got rd=%0d v=%b want rd=3 v=1", mem_rd, mem_valid); end
    n_tests++; if ({fwd_a, fwd_b, load_use} !== 3'b100) begin n_fail++;
      $display("FAIL fwd_flags: got %b want 100", {fwd_a, fwd_b, load_use}); end
  endtask

  task automatic test_load_use_stall();
    do_reset();
    ex_valid = 1; ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5; ex_result = 16'h0100;
    step(); id_rs = 1; id_rt = 5; #1;
    n_tests++; if ({fwd_a, fwd_b, load_use} !== 3'b001) begin n_fail++;
      $display("FAIL lu_flags: got %b want 001", {fwd_a, fwd_b, load_use}); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_result = 16'($urandom); ex_rd = 3'($urandom); ex_mem_rd = 0; ex_mem_wr = 1;
      step();
      n_tests++;
      if (mem_result !== 16'h0100 || mem_rd !== 3'd5 || mem_mem_rd !== 1'b1 ||
          mem_mem_wr !== 1'b0 || mem_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got res=%h rd=%0d rd_en=%b wr_en=%b v=%b want 0100 5 1 0 1",
                 i, mem_result, mem_rd, mem_mem_rd, mem_mem_wr, mem_valid);
      end
    end
    stall = 0;
  endtask

  task automatic test_flush_stall();
    do_reset();
    ex_valid = 1; ex_mem_wr = 1; ex_result = 16'h0040; ex_store_data = 16'hBEEF;
    stall = 1; flush = 1;
    step();
    n_tests++; if ({mem_valid, mem_mem_wr} !== 2'b00) begin n_fail++;
      $display("FAIL flush_over_stall: got v=%b wr=%b want 0 0", mem_valid, mem_mem_wr); end
    idle_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    ex_valid = 1; ex_halt = 1;
    step();
    n_tests++; if ({mem_halted, mem_valid, mem_reg_wr} !== 3'b110) begin n_fail++;
      $display("FAIL halt_capture: got %b want 110", {mem_halted, mem_valid, mem_reg_wr}); end
    ex_halt = 0; ex_result = 16'h1234; ex_reg_wr = 1; ex_rd = 2; id_rs = 2; id_rt = 2;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if ({mem_valid, fwd_a, fwd_b, load_use, mem_halted} !== 5'b00001) begin n_fail++;
        $display("FAIL halt_bubble%0d: got %b want 00001", i,
                 {mem_valid, fwd_a, fwd_b, load_use, mem_halted}); end
    end
    flush = 1; step(); flush = 0;
    n_tests++; if (mem_halted !== 1'b1) begin n_fail++;
      $display("FAIL halt_flush: got %b want 1", mem_halted); end
    rst = 1; step(); rst = 0;
    n_tests++; if ({mem_halted, mem_valid} !== 2'b00) begin n_fail++;
      $display("FAIL halt_rst: got %b want 00", {mem_halted, mem_valid}); end
    idle_inputs();
  endtask

  task automatic test_invalid();
    do_reset();
    ex_valid = 0; ex_reg_wr = 1; ex_mem_wr = 1; ex_result = 16'h5555;
    step();
    n_tests++; if ({mem_valid, mem_reg_wr, mem_mem_wr} !== 3'b000) begin n_fail++;
      $display("FAIL invalid_writes: got %b want 000", {mem_valid, mem_reg_wr, mem_mem_wr}); end
    idle_inputs();
  endtask

  task automatic test_err();
    do_reset();
    ex_valid = 1; ex_mem_rd = 1; ex_mem_wr = 1; ex_reg_wr = 1;
    step();
    n_tests++; if ({err, mem_mem_rd, mem_mem_wr, mem_valid} !== 4'b1001) begin n_fail++;
      $display("FAIL err_set: got %b want 1001", {err, mem_mem_rd, mem_mem_wr, mem_valid}); end
    ex_mem_rd = 0; ex_mem_wr = 0;
    for (int i = 0; i < 3; i++) begin
      ex_result = 16'($urandom); stall = (i == 1);
      step();
      n_tests++; if (err !== 1'b1) begin n_fail++;
        $display("FAIL err_sticky%0d: got %b want 1", i, err); end
    end
    stall = 0; rst = 1; step(); rst = 0;
    n_tests++; if (err !== 1'b0) begin n_fail++;
      $display("FAIL err_rst: got %b want 0", err); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic e_fa, e_fb, e_lu;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      ex_valid      = ($urandom_range(0, 4) != 0);
      ex_halt       = ($urandom_range(0, 49) == 0);
      ex_reg_wr     = 1'($urandom);
      ex_mem_rd     = ($urandom_range(0, 2) == 0);
      ex_mem_wr     = ($urandom_range(0, 3) == 0);
      ex_result     = 16'($urandom);
      ex_store_data = 16'($urandom);
      ex_pc_inc     = 16'($urandom);
      ex_rd         = 3'($urandom);
      step();
      id_rs = 3'($urandom); id_rt = 3'($urandom); #1;
      e_fa = m_valid && m_reg_wr && !m_mem_rd && (m_rd == id_rs);
      e_fb = m_valid && m_reg_wr && !m_mem_rd && (m_rd == id_rt);
      e_lu = m_valid && m_mem_rd && m_reg_wr && ((m_rd == id_rs) || (m_rd == id_rt));
      n_tests++;
      if ({mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halted, err} !==
          {m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_halted, m_err}) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: got %b want %b", i,
                 {mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halted, err},
                 {m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_halted, m_err});
      end
      n_tests++;
      if ({fwd_a, fwd_b, load_use} !== {e_fa, e_fb, e_lu}) begin
        n_fail++;
        $display("FAIL rand_hazard[%0d]: got %b want %b", i, {fwd_a, fwd_b, load_use},
                 {e_fa, e_fb, e_lu});
      end
      if (m_valid) begin
        n_tests++;
        if ({mem_result, mem_store_data, mem_pc_inc, mem_rd} !== {m_result, m_store, m_pc, m_rd})
        begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got %h want %h", i,
                   {mem_result, mem_store_data, mem_pc_inc, mem_rd}, {m_result, m_store, m_pc, m_rd});
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_forward();
    test_load_use_stall();
    test_flush_stall();
    test_halt();
    test_invalid();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
